// File: rtl/gpio_wb_irq_if.sv
// Wishbone classic bus bundle for the GPIO block.
// Member names are seen from the slave side: *_i flows master->slave and
// *_o flows slave->master.
//   adr_i/dat_i/we_i/sel_i/cyc_i/stb_i : request from master
//   dat_o/ack_o                        : response from slave
interface gpio_wb_irq_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;

  modport master (output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
                  input  dat_o, ack_o);
  modport slave  (input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
                  output dat_o, ack_o);
endinterface

// File: rtl/gpio_wb_irq.sv
// Wishbone-slave GPIO port with per-pin direction, synchronised inputs and
// per-pin edge-detect interrupts (W1C status).
//   clk_i, rst_ni : clock, async active-low reset
//   wb            : Wishbone slave bundle (one-cycle ack, reads and writes)
//   gpio_i        : asynchronous pin inputs
//   gpio_o        : OUT register
//   gpio_oe_o     : DIR register, 1 = drive
//   irq_o         : registered OR of enabled pending status bits

// Per-pin input path: synchroniser, previous-value flop and event select.
//   pin_i  : raw pin
//   any_i  : both-edge mode, overrides rise_i
//   rise_i : 1 = rising edge, 0 = falling edge
//   s_o    : synchronised pin value
//   ev_o   : edge event this cycle
module gpio_wb_irq_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic any_i,
  input  logic rise_i,
  output logic s_o,
  output logic ev_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   rise, fall;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o  = sync_q[SYNC_STAGES-1];
  assign rise = s_o & ~prev_q;
  assign fall = ~s_o & prev_q;
  assign ev_o = any_i ? (rise | fall) : (rise_i ? rise : fall);
endmodule

module gpio_wb_irq #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  gpio_wb_irq_if.slave     wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);
  localparam logic [29:0] OFF_OUT  = 30'd0;
  localparam logic [29:0] OFF_DIR  = 30'd1;
  localparam logic [29:0] OFF_IN   = 30'd2;
  localparam logic [29:0] OFF_IE   = 30'd3;
  localparam logic [29:0] OFF_IS   = 30'd4;
  localparam logic [29:0] OFF_RISE = 30'd5;
  localparam logic [29:0] OFF_ANY  = 30'd6;

  typedef enum logic {IDLE, ACK} state_e;

  state_e           state_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic [WIDTH-1:0] out_q, dir_q, ie_q, is_q, rise_q, any_q;
  logic [WIDTH-1:0] out_d, dir_d, ie_d, is_d, rise_d, any_d;
  logic             irq_q;

  logic [WIDTH-1:0] pin_s, pin_ev;
  logic [29:0]      off;
  logic             req, wr;
  logic [31:0]      mask32, rdata;
  logic [WIDTH-1:0] wmask, wdat;

  gpio_wb_irq_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin [WIDTH-1:0] (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pin_i  (gpio_i),
    .any_i  (any_q),
    .rise_i (rise_q),
    .s_o    (pin_s),
    .ev_o   (pin_ev)
  );

  // Word offset into the window; addresses below the base wrap to a huge
  // offset and fall into the unmapped default.
  assign off = wb.adr_i[31:2] - BASE_ADDR[31:2];
  assign req = (state_q == IDLE) & wb.cyc_i & wb.stb_i;
  assign wr  = req & wb.we_i;

  always_comb begin
    mask32 = '0;
    for (int b = 0; b < 32; b++) mask32[b] = wb.sel_i[b/8];
  end
  assign wmask = mask32[WIDTH-1:0];
  assign wdat  = wb.dat_i[WIDTH-1:0];

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ie_d   = ie_q;
    is_d   = is_q;
    rise_d = rise_q;
    any_d  = any_q;
    if (wr) begin
      case (off)
        OFF_OUT:  out_d  = (out_q  & ~wmask) | (wdat & wmask);
        OFF_DIR:  dir_d  = (dir_q  & ~wmask) | (wdat & wmask);
        OFF_IE:   ie_d   = (ie_q   & ~wmask) | (wdat & wmask);
        OFF_IS:   is_d   = is_q & ~(wdat & wmask);
        OFF_RISE: rise_d = (rise_q & ~wmask) | (wdat & wmask);
        OFF_ANY:  any_d  = (any_q  & ~wmask) | (wdat & wmask);
        default:  ;
      endcase
    end
    // OR-in events after the clear so a coincident event is not lost.
    is_d = is_d | pin_ev;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT:  rdata[WIDTH-1:0] = out_q;
      OFF_DIR:  rdata[WIDTH-1:0] = dir_q;
      OFF_IN:   rdata[WIDTH-1:0] = pin_s;
      OFF_IE:   rdata[WIDTH-1:0] = ie_q;
      OFF_IS:   rdata[WIDTH-1:0] = is_q;
      OFF_RISE: rdata[WIDTH-1:0] = rise_q;
      OFF_ANY:  rdata[WIDTH-1:0] = any_q;
      default:  ;
    endcase
  end

  // Bus FSM: ACK always returns to IDLE, so a held strobe is not re-served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q <= ACK;
          ack_q   <= 1'b1;
          if (!wb.we_i) dat_q <= rdata;
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      dir_q  <= '0;
      ie_q   <= '0;
      is_q   <= '0;
      rise_q <= '0;
      any_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ie_q   <= ie_d;
      is_q   <= is_d;
      rise_q <= rise_d;
      any_q  <= any_d;
      irq_q  <= |(is_q & ie_q);
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;
  assign wb.dat_o  = dat_q;
  assign wb.ack_o  = ack_q;

  logic unused_bits;
  assign unused_bits = ^{wb.dat_i, wb.adr_i[1:0], mask32};
endmodule

// File: tb/tb_gpio_wb_irq.sv
module tb_gpio_wb_irq;
  localparam int          W    = 16;
  localparam int          SY   = 2;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_i, gpio_o, gpio_oe_o;
  logic         irq_o;

  gpio_wb_irq_if wb();

  gpio_wb_irq #(.BASE_ADDR(BASE), .WIDTH(W), .SYNC_STAGES(SY)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wb        (wb),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  logic [31:0] last_rd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit rd; logic [31:0] data;} exp_t;
  exp_t         sbq[$];
  logic [W-1:0] hist[$];   // pin samples taken at each clock edge
  logic [W-1:0] m_out, m_dir, m_ie, m_is, m_rise, m_any;
  logic [W-1:0] ms, mp, mev, mclr, mwm, mw;
  logic [31:0]  rv;
  logic         m_irq, nirq;
  bit           m_busy;
  int           idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_dir = '0; m_ie = '0; m_is = '0; m_rise = '0; m_any = '0;
      m_irq = 1'b0; m_busy = 0;
      sbq.delete();
      hist.delete();
      for (int i = 0; i <= SY; i++) hist.push_back('0);
    end else begin
      // Synchronised value lags the pin by SY samples; prev one more.
      ms   = hist[hist.size()-SY];
      mp   = hist[hist.size()-SY-1];
      mev  = (m_any & (ms ^ mp)) | (~m_any & m_rise & ms & ~mp)
           | (~m_any & ~m_rise & ~ms & mp);
      nirq = |(m_is & m_ie);
      mclr = '0;
      if (m_busy) m_busy = 0;
      else if (wb.cyc_i && wb.stb_i) begin
        m_busy = 1;
        for (int b = 0; b < W; b++) mwm[b] = wb.sel_i[b/8];
        mw = wb.dat_i[W-1:0];
        if (wb.adr_i >= BASE && wb.adr_i < BASE + 32'h1C) idx = int'((wb.adr_i - BASE) >> 2);
        else idx = 99;
        if (wb.we_i) begin
          case (idx)
            0: m_out  = (m_out  & ~mwm) | (mw & mwm);
            1: m_dir  = (m_dir  & ~mwm) | (mw & mwm);
            3: m_ie   = (m_ie   & ~mwm) | (mw & mwm);
            4: mclr   = mw & mwm;
            5: m_rise = (m_rise & ~mwm) | (mw & mwm);
            6: m_any  = (m_any  & ~mwm) | (mw & mwm);
            default: ;
          endcase
          sbq.push_back('{1'b0, 32'h0});
        end else begin
          case (idx)
            0: rv = 32'(m_out);
            1: rv = 32'(m_dir);
            2: rv = 32'(ms);
            3: rv = 32'(m_ie);
            4: rv = 32'(m_is);
            5: rv = 32'(m_rise);
            6: rv = 32'(m_any);
            default: rv = 32'h0;
          endcase
          sbq.push_back('{1'b1, rv});
        end
      end
      m_is  = (m_is & ~mclr) | mev;
      m_irq = nirq;
      hist.push_back(gpio_i);
      void'(hist.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("gpio_o", 32'(gpio_o), 32'(m_out));
      chk("gpio_oe_o", 32'(gpio_oe_o), 32'(m_dir));
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("ack_o", 32'(wb.ack_o), 32'(m_busy));
      if (wb.ack_o) begin
        if (sbq.size() == 0) begin
          checks++; errs++;
          $display("FAIL ack_unexpected: got ack with no request outstanding");
        end else begin
          e = sbq.pop_front();
          if (e.rd) begin
            chk("rdata", wb.dat_o, e.data);
            last_rd = wb.dat_o;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xfer(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int n = 0;
    @(negedge clk);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we;
    wb.adr_i = a; wb.dat_i = d; wb.sel_i = s;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.ack_o && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; gpio_i = '0;
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_oe", 32'(gpio_oe_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_ack", 32'(wb.ack_o), 32'h0);
    chk("rst_dat", wb.dat_o, 32'h0);
    rst_n = 1'b1;

    // basic access
    xfer(1, BASE + 32'h0, 32'h0000_00A5, 4'b0001);
    chk("out_a5", 32'(gpio_o), 32'h00A5);
    xfer(0, BASE + 32'h0, 32'h0, 4'hF);
    chk("rd_out", last_rd, 32'h0000_00A5);

    // byte select and IN read
    xfer(1, BASE + 32'h4, 32'h0000_FFFF, 4'b0010);
    chk("dir_bytesel", 32'(gpio_oe_o), 32'hFF00);
    @(negedge clk); gpio_i = 16'h1234;
    repeat (3) @(negedge clk);
    xfer(0, BASE + 32'h8, 32'h0, 4'hF);
    chk("rd_in", last_rd, 32'h0000_1234);

    // rising edge interrupt
    @(negedge clk); gpio_i = '0;
    repeat (4) @(negedge clk);
    xfer(1, BASE + 32'h10, 32'hFFFF, 4'hF);
    xfer(1, BASE + 32'hC, 32'h1, 4'hF);
    xfer(1, BASE + 32'h14, 32'h1, 4'hF);
    @(negedge clk); gpio_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_early", 32'(irq_o), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq_o), 32'h1);
    xfer(1, BASE + 32'h10, 32'h1, 4'hF);
    @(negedge clk);
    chk("irq_cleared", 32'(irq_o), 32'h0);
    gpio_i[0] = 1'b0;
    repeat (5) @(negedge clk);
    xfer(0, BASE + 32'h10, 32'h0, 4'hF);
    chk("fall_ignored", 32'(last_rd[0]), 32'h0);

    // ANY mode with coincident W1C
    xfer(1, BASE + 32'h18, 32'h2, 4'hF);
    xfer(1, BASE + 32'hC, 32'h3, 4'hF);
    @(negedge clk); gpio_i[1] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(1, BASE + 32'h10, 32'h2, 4'hF);
    xfer(0, BASE + 32'h10, 32'h0, 4'hF);
    chk("set_wins", 32'(last_rd[1]), 32'h1);

    // unmapped read, then reset during ACK
    xfer(0, BASE + 32'h40, 32'h0, 4'hF);
    chk("unmapped", last_rd, 32'h0);
    xfer(1, BASE + 32'h0, 32'hFFFF, 4'hF);
    xfer(1, BASE + 32'h4, 32'hFFFF, 4'hF);
    @(negedge clk);
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0; wb.adr_i = BASE; wb.sel_i = 4'hF;
    @(posedge clk); #1;
    chk("ack_before_rst", 32'(wb.ack_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ack_async_drop", 32'(wb.ack_o), 32'h0);
    chk("rst2_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst2_oe", 32'(gpio_oe_o), 32'h0);
    chk("rst2_irq", 32'(irq_o), 32'h0);
    chk("rst2_dat", wb.dat_o, 32'h0);
    wb.cyc_i = 0; wb.stb_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        @(negedge clk);
        gpio_i = gpio_i ^ W'($urandom_range(0, 16'hFFFF));
      end else if (r < 9) begin
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) a = BASE - 32'h4;
        else a = BASE + 32'($urandom_range(0, 8)) * 4 + 32'($urandom_range(0, 3));
        xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
